// File: rtl/led_pattern_gen.sv
// Parametrised LED pattern generator: binary, walking-one, bounce and PWM breathe.
// Define LED_PATTERN_OBUF_EN to route every led bit through its own OBUF instance.
module led_pattern_gen #(
    parameter int NUM_LEDS  = 4,
    parameter int LOG2DELAY = 25,
    parameter int PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] led,
    output logic                tick,
    output logic                dir
);

    localparam logic [1:0] MODE_BIN     = 2'b00;
    localparam logic [1:0] MODE_WALK    = 2'b01;
    localparam logic [1:0] MODE_BOUNCE  = 2'b10;
    localparam logic [1:0] MODE_BREATHE = 2'b11;

    localparam logic [0:0] DIR_UP   = 1'b0;
    localparam logic [0:0] DIR_DOWN = 1'b1;

    localparam logic [LOG2DELAY-1:0] PRE_MAX  = '1;
    localparam logic [LOG2DELAY-1:0] PRE_ONE  = LOG2DELAY'(1);
    localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;
    localparam logic [PWM_BITS-1:0]  DUTY_ONE = PWM_BITS'(1);
    localparam logic [NUM_LEDS-1:0]  PAT_ONE  = NUM_LEDS'(1);

    logic [LOG2DELAY-1:0] pre_cnt_q, pre_cnt_d;
    logic [NUM_LEDS-1:0]  pat_q, pat_d;
    logic [PWM_BITS-1:0]  duty_q, duty_d;
    logic [PWM_BITS-1:0]  phase_q, phase_d;
    logic [0:0]           dir_q, dir_d;
    logic [1:0]           mode_q, mode_d;
    logic                 tick_q, tick_d;

    logic                 mode_chg;
    logic                 step;
    logic [NUM_LEDS-1:0]  pat_shl, pat_shr;
    logic [NUM_LEDS-1:0]  led_d;

    always_comb begin
        mode_chg  = (mode != mode_q);
        step      = enable && (pre_cnt_q == PRE_MAX) && !mode_chg;
        pat_shl   = pat_q << 1;
        pat_shr   = pat_q >> 1;

        pre_cnt_d = pre_cnt_q;
        pat_d     = pat_q;
        duty_d    = duty_q;
        phase_d   = phase_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        tick_d    = 1'b0;

        // phase free-runs on enabled edges so the PWM carrier never stalls on steps
        if (enable) begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
            phase_d   = phase_q + DUTY_ONE;
        end

        if (mode_chg) begin
            mode_d    = mode;
            pre_cnt_d = '0;
            dir_d     = DIR_UP;
            duty_d    = '0;
            pat_d     = (mode == MODE_WALK || mode == MODE_BOUNCE) ? PAT_ONE : '0;
        end else if (step) begin
            tick_d = 1'b1;
            case (mode_q)
                MODE_BIN:  pat_d = pat_q + PAT_ONE;
                MODE_WALK: pat_d = pat_shl | (pat_q >> (NUM_LEDS - 1));
                MODE_BOUNCE: begin
                    if (NUM_LEDS > 1) begin
                        if (dir_q == DIR_UP) begin
                            pat_d = pat_shl;
                            if (pat_shl[NUM_LEDS-1]) dir_d = DIR_DOWN;
                        end else begin
                            pat_d = pat_shr;
                            if (pat_shr == PAT_ONE) dir_d = DIR_UP;
                        end
                    end
                end
                default: begin
                    // duty turns around at the rails, so it never wraps
                    if (dir_q == DIR_UP) begin
                        duty_d = duty_q + DUTY_ONE;
                        if (duty_d == DUTY_MAX) dir_d = DIR_DOWN;
                    end else begin
                        duty_d = duty_q - DUTY_ONE;
                        if (duty_d == '0) dir_d = DIR_UP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q <= '0;
            pat_q     <= '0;
            duty_q    <= '0;
            phase_q   <= '0;
            dir_q     <= DIR_UP;
            mode_q    <= MODE_BIN;
            tick_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            pat_q     <= pat_d;
            duty_q    <= duty_d;
            phase_q   <= phase_d;
            dir_q     <= dir_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        led_d = pat_q;
        if (mode_q == MODE_BREATHE) led_d = {NUM_LEDS{phase_q < duty_q}};
    end

    assign tick = tick_q;
    assign dir  = dir_q;

`ifdef LED_PATTERN_OBUF_EN
    for (genvar i = 0; i < NUM_LEDS; i++) begin : obuf_gen
        OBUF #(
            .IOSTANDARD("LVCMOS33"),
            .SLEW      ("SLOW")
        ) OBUF_LED (
            .O(led[i]),
            .I(led_d[i])
        );
    end
`else
    assign led = led_d;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: vector table fed through an expected-value queue,
// plus a hand-driven asynchronous reset in the middle of a bounce.
module tb_led_pattern_gen;

    localparam int N  = 4;
    localparam int LD = 2;
    localparam int PB = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [N-1:0] led;
    logic         tick;
    logic         dir;

    typedef struct packed {
        logic         rst;
        logic         en;
        logic [1:0]   mode;
        logic [N-1:0] led;
        logic         tick;
        logic         dir;
        logic [3:0]   grp;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    led_pattern_gen #(.NUM_LEDS(N), .LOG2DELAY(LD), .PWM_BITS(PB)) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .mode  (mode),
        .led   (led),
        .tick  (tick),
        .dir   (dir)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, expected completion");
        $fatal(1);
    end

    task automatic add(input logic r, input logic e, input logic [1:0] m,
                       input logic [N-1:0] l, input logic t, input logic d, input logic [3:0] g);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.led = l; v.tick = t; v.dir = d; v.grp = g;
        vecs.push_back(v);
    endtask

    task automatic add_reset(input logic [3:0] g);
        add(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, g);
        add(1'b1, 1'b0, 2'b00, '0, 1'b0, 1'b0, g);
    endtask

    task automatic check_out();
        vec_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard #%0d: got led=%b with no expected entry queued", n_vec, led);
            return;
        end
        e = exp_q.pop_front();
        if (led !== e.led || tick !== e.tick || dir !== e.dir) begin
            n_err++;
            $display("FAIL grp%0d vec#%0d: got led=%b tick=%b dir=%b, expected led=%b tick=%b dir=%b",
                     e.grp, n_vec, led, tick, dir, e.led, e.tick, e.dir);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        rst = v.rst; enable = v.en; mode = v.mode;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        int bl[8] = '{1, 2, 4, 8, 4, 2, 1, 2};
        int bd[8] = '{0, 0, 0, 1, 1, 1, 0, 0};
        int dt[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
        vec_t v;

        // group 0: reset, then binary count every 4 edges, 15 -> 0 at edge 64
        add_reset(4'd0);
        for (int k = 1; k <= 64; k++)
            add(1'b0, 1'b1, 2'b00, N'((k / 4) % 16), (k % 4) == 0, 1'b0, 4'd1);

        // group 2: walk, first edge loads 0001
        add_reset(4'd2);
        for (int j = 1; j <= 17; j++)
            add(1'b0, 1'b1, 2'b01, N'(1 << (((j - 1) / 4) % 4)),
                (j > 1) && ((j - 1) % 4 == 0), 1'b0, 4'd3);

        // group 4: bounce turnaround
        add_reset(4'd4);
        for (int j = 1; j <= 29; j++)
            add(1'b0, 1'b1, 2'b10, N'(bl[(j - 1) / 4]),
                (j > 1) && ((j - 1) % 4 == 0), bd[(j - 1) / 4] != 0, 4'd5);

        // group 6: breathe, phase = edge count mod 4 since reset
        add_reset(4'd6);
        for (int j = 1; j <= 29; j++)
            add(1'b0, 1'b1, 2'b11, ((j % 4) < dt[(j - 1) / 4]) ? {N{1'b1}} : {N{1'b0}},
                (j > 1) && ((j - 1) % 4 == 0), bd[(j - 1) / 4] != 0, 4'd7);

        // group 8: freeze mid-count, then mode change on a would-be step edge
        add_reset(4'd8);
        add(1'b0, 1'b1, 2'b01, 4'b0001, 1'b0, 1'b0, 4'd9);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 2'b01, 4'b0001, 1'b0, 1'b0, 4'd9);
        add(1'b0, 1'b1, 2'b01, 4'b0010, 1'b1, 1'b0, 4'd9);
        add(1'b0, 1'b1, 2'b01, 4'b0010, 1'b0, 1'b0, 4'd9);
        for (int j = 0; j < 10; j++) add(1'b0, 1'b0, 2'b01, 4'b0010, 1'b0, 1'b0, 4'd10);
        add(1'b0, 1'b1, 2'b01, 4'b0010, 1'b0, 1'b0, 4'd11);
        add(1'b0, 1'b1, 2'b01, 4'b0010, 1'b0, 1'b0, 4'd11);
        add(1'b0, 1'b1, 2'b01, 4'b0100, 1'b1, 1'b0, 4'd11);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 2'b01, 4'b0100, 1'b0, 1'b0, 4'd11);
        add(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 4'd12);
        for (int j = 0; j < 3; j++) add(1'b0, 1'b1, 2'b00, 4'b0000, 1'b0, 1'b0, 4'd12);
        add(1'b0, 1'b1, 2'b00, 4'b0001, 1'b1, 1'b0, 4'd12);

        // group 13: bounce up to the edge where pat=0100 on the way down (tick high)
        add_reset(4'd13);
        for (int j = 1; j <= 17; j++)
            add(1'b0, 1'b1, 2'b10, N'(bl[(j - 1) / 4]),
                (j > 1) && ((j - 1) % 4 == 0), bd[(j - 1) / 4] != 0, 4'd13);

        foreach (vecs[i]) apply(vecs[i]);

        // async reset between edges: outputs clear without a clock
        #1;
        rst = 1'b1;
        v = '{rst: 1'b1, en: 1'b1, mode: 2'b10, led: '0, tick: 1'b0, dir: 1'b0, grp: 4'd14};
        exp_q.push_back(v);
        #1;
        check_out();

        // release with bounce selected: first edge reinitialises to 0001
        apply('{rst: 1'b0, en: 1'b1, mode: 2'b10, led: 4'b0001, tick: 1'b0, dir: 1'b0, grp: 4'd15});
        apply('{rst: 1'b0, en: 1'b1, mode: 2'b10, led: 4'b0001, tick: 1'b0, dir: 1'b0, grp: 4'd15});

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
